rr_stream_packer: RTL and testbench

- Sits directly downstream of the 4-channel round-robin FIFO arbiter and consumes its serialized byte stream (data + valid).
- The channel of each byte is implied by a free-running round-robin slot counter, reset-aligned with the arbiter.
- Packs bytes per channel into 32-bit words tagged with channel and byte count.
- Delivers words through a small output queue with a valid/ready handshake; flush emits partial words.

---
 rtl/rr_stream_packer.sv | 189 ++++++++++++++++++
 tb/tb_rr_stream_packer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_packer.sv
// rtl/rr_stream_packer.sv - per-channel byte packer with output word queue and flush scan
// Optional: define PACKER_PARITY_EN to add out_par (per-byte even parity of the head word).
module rr_stream_packer #(
  parameter int unsigned SLOT_OFFSET = 0,
  parameter int unsigned OUT_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        flush,
  output logic [31:0] out_data,
  output logic [1:0]  out_ch,
  output logic [2:0]  out_cnt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
`ifdef PACKER_PARITY_EN
  output logic [3:0]  out_par,
`endif
  output logic        busy
);

  localparam int OW = $clog2(OUT_DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_L = OW'(OUT_DEPTH);
  localparam logic [1:0] SLOT_RST = SLOT_OFFSET[1:0];
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [1:0]    slot_q, slot_d;
  logic [31:0]   acc_q [4];
  logic [31:0]   acc_d [4];
  logic [2:0]    cnt_q [4];
  logic [2:0]    cnt_d [4];
  logic [0:0]    state_q, state_d;
  logic [1:0]    scan_q, scan_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   qd_q [OUT_DEPTH];
  logic [31:0]   qd_d [OUT_DEPTH];
  logic [1:0]    qc_q [OUT_DEPTH];
  logic [1:0]    qc_d [OUT_DEPTH];
  logic [2:0]    qn_q [OUT_DEPTH];
  logic [2:0]    qn_d [OUT_DEPTH];
`ifdef PACKER_PARITY_EN
  logic [3:0]    qp_q [OUT_DEPTH];
  logic [3:0]    qp_d [OUT_DEPTH];
  logic [3:0]    push_par;
`endif
  logic [OW-1:0] occ_q, occ_d, widx;

  logic [2:0]  cur_cnt, scan_cnt, push_cnt;
  logic [31:0] push_data;
  logic [1:0]  push_ch;
  logic        pop, space, comp, hit, emit, advance, push;

  assign cur_cnt  = cnt_q[slot_q];
  assign scan_cnt = cnt_q[scan_q];
  assign pop      = (occ_q != '0) && out_ready;
  assign space    = (occ_q != DEPTH_L) || pop;
  assign comp     = in_valid && (cur_cnt == 3'd3);
  // A byte landing on the scanned channel is appended first; emission waits a cycle.
  assign hit      = in_valid && (slot_q == scan_q);
  assign emit     = (state_q == S_FLUSH) && !hit && (scan_cnt != 3'd0) && space && !comp;
  assign advance  = (state_q == S_FLUSH) && !hit && ((scan_cnt == 3'd0) || emit);
  assign push     = (comp && space) || emit;
  assign push_data = comp ? {in_data, acc_q[slot_q][23:0]} : acc_q[scan_q];
  assign push_ch   = comp ? slot_q : scan_q;
  assign push_cnt  = comp ? 3'd4 : scan_cnt;
  assign widx      = occ_q - OW'(pop);

`ifdef PACKER_PARITY_EN
  always_comb begin
    push_par = '0;
    for (int b = 0; b < 4; b++) push_par[b] = ^push_data[8*b +: 8];
  end
`endif

  always_comb begin
    slot_d  = slot_q + 2'd1;
    state_d = state_q;
    scan_d  = scan_q;
    ovf_d   = ovf_q || (comp && !space);
    occ_d   = occ_q + OW'(push) - OW'(pop);
    for (int i = 0; i < 4; i++) begin
      acc_d[i] = acc_q[i];
      cnt_d[i] = cnt_q[i];
    end
    if (emit) begin
      acc_d[scan_q] = '0;
      cnt_d[scan_q] = '0;
    end
    if (comp) begin
      acc_d[slot_q] = '0;
      cnt_d[slot_q] = '0;
    end else if (in_valid) begin
      acc_d[slot_q][{cur_cnt[1:0], 3'b000} +: 8] = in_data;
      cnt_d[slot_q] = cur_cnt + 3'd1;
    end
    if (state_q == S_IDLE) begin
      if (flush) begin
        state_d = S_FLUSH;
        scan_d  = 2'd0;
      end
    end else if (advance) begin
      if (scan_q == 2'd3) state_d = S_IDLE;
      else scan_d = scan_q + 2'd1;
    end
    for (int i = 0; i < OUT_DEPTH; i++) begin
      qd_d[i] = qd_q[i];
      qc_d[i] = qc_q[i];
      qn_d[i] = qn_q[i];
`ifdef PACKER_PARITY_EN
      qp_d[i] = qp_q[i];
`endif
    end
    // Shift-register queue: entry 0 is always the head.
    if (pop) begin
      for (int i = 0; i < OUT_DEPTH - 1; i++) begin
        qd_d[i] = qd_q[i+1];
        qc_d[i] = qc_q[i+1];
        qn_d[i] = qn_q[i+1];
`ifdef PACKER_PARITY_EN
        qp_d[i] = qp_q[i+1];
`endif
      end
    end
    for (int i = 0; i < OUT_DEPTH; i++) begin
      if (push && (widx == OW'(i))) begin
        qd_d[i] = push_data;
        qc_d[i] = push_ch;
        qn_d[i] = push_cnt;
`ifdef PACKER_PARITY_EN
        qp_d[i] = push_par;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q  <= SLOT_RST;
      state_q <= S_IDLE;
      scan_q  <= '0;
      ovf_q   <= 1'b0;
      occ_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      for (int i = 0; i < OUT_DEPTH; i++) begin
        qd_q[i] <= '0;
        qc_q[i] <= '0;
        qn_q[i] <= '0;
`ifdef PACKER_PARITY_EN
        qp_q[i] <= '0;
`endif
      end
    end else begin
      slot_q  <= slot_d;
      state_q <= state_d;
      scan_q  <= scan_d;
      ovf_q   <= ovf_d;
      occ_q   <= occ_d;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= acc_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      for (int i = 0; i < OUT_DEPTH; i++) begin
        qd_q[i] <= qd_d[i];
        qc_q[i] <= qc_d[i];
        qn_q[i] <= qn_d[i];
`ifdef PACKER_PARITY_EN
        qp_q[i] <= qp_d[i];
`endif
      end
    end
  end

  assign out_valid = (occ_q != '0);
  assign out_data  = out_valid ? qd_q[0] : 32'd0;
  assign out_ch    = out_valid ? qc_q[0] : 2'd0;
  assign out_cnt   = out_valid ? qn_q[0] : 3'd0;
`ifdef PACKER_PARITY_EN
  assign out_par   = out_valid ? qp_q[0] : 4'd0;
`endif
  assign overflow  = ovf_q;
  assign busy      = (state_q == S_FLUSH);

endmodule

// File: tb/tb_rr_stream_packer.sv
// tb/tb_rr_stream_packer.sv - scoreboard bench for rr_stream_packer against a byte-queue model
`timescale 1ns/1ps
module tb_rr_stream_packer;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_ch;
  logic [2:0]  out_cnt;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overflow;
  logic        busy;
`ifdef PACKER_PARITY_EN
  logic [3:0]  out_par;
`endif

  always #5 clk = ~clk;

  rr_stream_packer #(.SLOT_OFFSET(0), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .flush(flush),
    .out_data(out_data), .out_ch(out_ch), .out_cnt(out_cnt), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow),
`ifdef PACKER_PARITY_EN
    .out_par(out_par),
`endif
    .busy(busy)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  ch;
    logic [2:0]  n;
  } word_t;

  int n_tests = 0;
  int n_fail  = 0;
  int n_words = 0;
  logic [31:0] last_data = '0;

  logic [7:0] m_bytes [4][$];
  word_t      m_fifo[$];
  word_t      exp_q[$];
  int         m_slot = 0;
  int         m_scan = 0;
  bit         m_flushing = 1'b0;
  bit         m_ovf = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic word_t pack_ch(int c);
    word_t w;
    w.d = '0;
    for (int i = 0; i < m_bytes[c].size(); i++) w.d[8*i +: 8] = m_bytes[c][i];
    w.ch = 2'(c);
    w.n  = 3'(m_bytes[c].size());
    return w;
  endfunction

  function automatic void m_push(word_t w);
    m_fifo.push_back(w);
    exp_q.push_back(w);
  endfunction

  // Model of one clock edge, evaluated with the inputs that were applied at that edge.
  function automatic void model_edge(bit v, logic [7:0] d, bit f, bit r, bit rs);
    bit pop, space, comp, do_emit, adv;
    int ch;
    word_t w;
    if (!rs) begin
      for (int c = 0; c < 4; c++) m_bytes[c].delete();
      m_fifo.delete();
      exp_q.delete();
      m_slot = 0; m_scan = 0; m_flushing = 0; m_ovf = 0;
      return;
    end
    pop   = (m_fifo.size() > 0) && r;
    space = (m_fifo.size() - (pop ? 1 : 0)) < DEPTH;
    ch    = m_slot;
    comp  = v && (m_bytes[ch].size() == 3);
    do_emit = 0; adv = 0;
    if (m_flushing) begin
      if (v && ch == m_scan) adv = 0;
      else if (m_bytes[m_scan].size() == 0) adv = 1;
      else if (!comp && space) begin do_emit = 1; adv = 1; end
    end
    if (pop) void'(m_fifo.pop_front());
    if (v) m_bytes[ch].push_back(d);
    if (comp) begin
      w = pack_ch(ch);
      m_bytes[ch].delete();
      if (space) m_push(w);
      else m_ovf = 1;
    end
    if (do_emit) begin
      w = pack_ch(m_scan);
      m_bytes[m_scan].delete();
      m_push(w);
    end
    if (m_flushing) begin
      if (adv) begin
        if (m_scan == 3) m_flushing = 0;
        else m_scan++;
      end
    end else if (f) begin
      m_flushing = 1;
      m_scan = 0;
    end
    m_slot = (m_slot + 1) % 4;
  endfunction

  task automatic step(bit v, logic [7:0] d, bit f, bit r, bit rs = 1'b1);
    in_valid = v; in_data = d; flush = f; out_ready = r; rst_n = rs;
    @(posedge clk);
    model_edge(v, d, f, r, rs);
    #1;
  endtask

  // Monitor: compares every handshake against the scoreboard, plus status flags.
  always @(negedge clk) begin
    if (rst_n) begin
      word_t e;
      check("out_valid", 32'(out_valid), 32'(m_fifo.size() > 0));
      check("busy", 32'(busy), 32'(m_flushing));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (!out_valid) check("empty_head", {out_data[28:0], out_cnt}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("word_data", out_data, e.d);
          check("word_ch", 32'(out_ch), 32'(e.ch));
          check("word_cnt", 32'(out_cnt), 32'(e.n));
`ifdef PACKER_PARITY_EN
          for (int b = 0; b < 4; b++) check("word_par", 32'(out_par[b]), 32'(^e.d[8*b +: 8]));
`endif
          n_words++;
          last_data = out_data;
        end
      end
    end
  end

  task automatic do_reset();
    step(0, 8'h00, 0, 0, 1'b0);
  endtask

  initial begin
    int w0, bcnt;
    do_reset();
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_ch_cnt", {27'd0, out_ch, out_cnt}, 32'd0);
    check("rst_flags", {30'd0, overflow, busy}, 32'd0);

    // Sixteen consecutive bytes, consumer always ready.
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i + 1), 0, 1);
      if (i == 12) begin
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_word0", out_data, 32'h0D090501);
        check("lat_ch0", 32'(out_ch), 32'd0);
      end
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1);
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);

    // Same bytes with the consumer stalled: two words kept, two dropped.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i + 1), 0, 0);
      if (i == 13) check("t2_ovf_before", 32'(overflow), 32'd0);
      if (i == 14) check("t2_ovf_after", 32'(overflow), 32'd1);
    end
    w0 = n_words;
    for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 1);
    check("t2_drain2", 32'(n_words - w0), 32'd2);
    check("t2_empty", 32'(out_valid), 32'd0);

    // Partial words flushed.
    do_reset();
    step(1, 8'hAA, 0, 1);
    step(1, 8'hBB, 0, 1);
    step(1, 8'hCC, 0, 1);
    w0 = n_words;
    step(0, 8'h00, 1, 1);
    bcnt = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      bcnt++;
      step(0, 8'h00, 0, 1);
    end
    check("t3_busy_cycles", 32'(bcnt), 32'd4);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1);
    check("t3_words", 32'(n_words - w0), 32'd3);
    check("t3_last", last_data, 32'h000000CC);

    // Flush into a stalled queue.
    do_reset();
    step(1, 8'hAA, 0, 0);
    step(1, 8'hBB, 0, 0);
    step(1, 8'hCC, 0, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 0);
    check("t4_stall_busy", 32'(busy), 32'd1);
    check("t4_stall_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 20 && busy; i++) step(0, 8'h00, 0, 1);
    check("t4_busy_done", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check("t4_last", last_data, 32'h000000CC);

    // Reset while words are queued and a flush is stalled.
    do_reset();
    step(1, 8'hAA, 0, 0);
    step(1, 8'hBB, 0, 0);
    step(1, 8'hCC, 0, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0);
    do_reset();
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_flags", {30'd0, overflow, busy}, 32'd0);
    w0 = n_words;
    for (int i = 0; i < 16; i++) step(i % 4 == 0, 8'h21 + 8'(i / 4), 0, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1);
    check("t5_words", 32'(n_words - w0), 32'd1);
    check("t5_word", last_data, 32'h24232221);

    // Randomized traffic with occasional flushes.
    do_reset();
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom_range(0, 255)),
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6);
    for (int i = 0; i < 12; i++) step(0, 8'h00, 0, 1);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

`ifdef PACKER_PARITY_EN
    do_reset();
    for (int i = 0; i < 16; i++) begin
      logic [31:0] pw;
      pw = 32'h07030100;
      step(i % 4 == 0, pw[8*(i/4) +: 8], 0, 0);
    end
    check("par_word", out_data, 32'h07030100);
    check("par_bits", 32'(out_par), 32'b1010);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
